// File: rtl/battleship_game_core.sv
// Battleship game engine: owns both boards, cursor, ship placement, shot resolution,
// turn timer and win/lose detection; the renderer reads cells through a combinational port.
module battleship_game_core #(
    parameter int BOARD_N    = 5,
    parameter int MAX_SHIPS  = 5,
    parameter int TURN_TICKS = 10,
    parameter int WRAP       = 0,
    localparam int CW        = $clog2(BOARD_N),
    localparam int SW        = $clog2(MAX_SHIPS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_start,
    input  logic [SW-1:0] i_ships_req,
    input  logic          i_confirm,
    input  logic          i_move_up,
    input  logic          i_move_down,
    input  logic          i_move_left,
    input  logic          i_move_right,
    input  logic          i_fire,
    input  logic [CW-1:0] i_rd_i,
    input  logic [CW-1:0] i_rd_j,
    output logic [1:0]    o_rd_player_cell,
    output logic [1:0]    o_rd_pc_cell,
    output logic [2:0]    o_state,
    output logic [CW-1:0] o_cursor_i,
    output logic [CW-1:0] o_cursor_j,
    output logic [SW-1:0] o_ships_target,
    output logic [SW-1:0] o_ships_placed,
    output logic [SW-1:0] o_player_left,
    output logic [SW-1:0] o_pc_left,
    output logic          o_timeout
);

    localparam int TW = $clog2(TURN_TICKS + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DECIDE   = 3'd1;
    localparam logic [2:0] S_PLACE    = 3'd2;
    localparam logic [2:0] S_PC_PLACE = 3'd3;
    localparam logic [2:0] S_PLAYER   = 3'd4;
    localparam logic [2:0] S_PC_TURN  = 3'd5;
    localparam logic [2:0] S_WIN      = 3'd6;
    localparam logic [2:0] S_LOSE     = 3'd7;

    localparam logic [1:0] C_EMPTY = 2'b00;
    localparam logic [1:0] C_SHIP  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_HIT   = 2'b11;

    localparam logic [CW:0]   LP_N     = (CW + 1)'(BOARD_N);
    localparam logic [CW-1:0] LP_LAST  = CW'(BOARD_N - 1);
    localparam logic [SW-1:0] LP_MAXS  = SW'(MAX_SHIPS);
    localparam logic [TW-1:0] LP_TLAST = TW'(TURN_TICKS - 1);
    localparam logic [7:0]    LP_SEED  = 8'h01;

    logic [1:0]    r_pl [BOARD_N][BOARD_N];
    logic [1:0]    r_pc [BOARD_N][BOARD_N];
    logic [2:0]    r_state;
    logic [CW-1:0] r_ci;
    logic [CW-1:0] r_cj;
    logic [SW-1:0] r_target;
    logic [SW-1:0] r_placed;
    logic [SW-1:0] r_pleft;
    logic [SW-1:0] r_cleft;
    logic [TW-1:0] r_timer;
    logic          r_timeout;
    logic [7:0]    r_lfsr;

    logic [2:0]    w_state_nx;
    logic [CW-1:0] w_ci_nx;
    logic [CW-1:0] w_cj_nx;
    logic [SW-1:0] w_target_nx;
    logic [SW-1:0] w_placed_nx;
    logic [SW-1:0] w_pleft_nx;
    logic [SW-1:0] w_cleft_nx;
    logic [TW-1:0] w_timer_nx;
    logic [TW-1:0] w_timer_d;
    logic          w_timeout_nx;
    logic          w_clear;
    logic          w_pl_we;
    logic [CW-1:0] w_pl_wi;
    logic [CW-1:0] w_pl_wj;
    logic [1:0]    w_pl_wd;
    logic          w_pc_we;
    logic [CW-1:0] w_pc_wi;
    logic [CW-1:0] w_pc_wj;
    logic [1:0]    w_pc_wd;

    logic [CW-1:0] w_cand_i;
    logic [CW-1:0] w_cand_j;
    logic          w_cand_ok;
    logic          w_rd_ok;
    logic [1:0]    w_pl_cur;
    logic [1:0]    w_pc_cur;
    logic [1:0]    w_pl_cand;
    logic [1:0]    w_pc_cand;

    function automatic logic [CW-1:0] f_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == {CW{1'b0}}) begin
            if (WRAP != 0) r = LP_LAST;
            else           r = v;
        end else begin
            r = v - CW'(1);
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] f_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == LP_LAST) begin
            if (WRAP != 0) r = {CW{1'b0}};
            else           r = v;
        end else begin
            r = v + CW'(1);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] f_clamp(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        if (v == {SW{1'b0}})  r = SW'(1);
        else if (v > LP_MAXS) r = LP_MAXS;
        else                  r = v;
        return r;
    endfunction

    // The LFSR window doubles as the PC's random (row, column) pick
    assign w_cand_i  = r_lfsr[CW-1:0];
    assign w_cand_j  = r_lfsr[2*CW-1:CW];
    assign w_cand_ok = ({1'b0, w_cand_i} < LP_N) && ({1'b0, w_cand_j} < LP_N);
    assign w_rd_ok   = ({1'b0, i_rd_i} < LP_N) && ({1'b0, i_rd_j} < LP_N);
    assign w_pl_cur  = r_pl[r_ci][r_cj];
    assign w_pc_cur  = r_pc[r_ci][r_cj];
    assign w_pl_cand = w_cand_ok ? r_pl[w_cand_i][w_cand_j] : C_EMPTY;
    assign w_pc_cand = w_cand_ok ? r_pc[w_cand_i][w_cand_j] : C_EMPTY;

    assign o_rd_player_cell = w_rd_ok ? r_pl[i_rd_i][i_rd_j] : C_EMPTY;
    assign o_rd_pc_cell     = w_rd_ok ? r_pc[i_rd_i][i_rd_j] : C_EMPTY;

    // Next-state, counter and board-write decisions
    always_comb begin
        w_state_nx   = r_state;
        w_ci_nx      = r_ci;
        w_cj_nx      = r_cj;
        w_target_nx  = r_target;
        w_placed_nx  = r_placed;
        w_pleft_nx   = r_pleft;
        w_cleft_nx   = r_cleft;
        w_timer_nx   = r_timer;
        w_timeout_nx = 1'b0;
        w_clear      = 1'b0;
        w_pl_we      = 1'b0;
        w_pl_wi      = r_ci;
        w_pl_wj      = r_cj;
        w_pl_wd      = C_EMPTY;
        w_pc_we      = 1'b0;
        w_pc_wi      = r_ci;
        w_pc_wj      = r_cj;
        w_pc_wd      = C_EMPTY;

        if ((r_state == S_PLACE) || (r_state == S_PLAYER)) begin
            if (i_move_up)         w_ci_nx = f_dec(r_ci);
            else if (i_move_down)  w_ci_nx = f_inc(r_ci);
            else if (i_move_left)  w_cj_nx = f_dec(r_cj);
            else if (i_move_right) w_cj_nx = f_inc(r_cj);
            else                   w_ci_nx = r_ci;
        end else begin
            w_ci_nx = r_ci;
        end

        case (r_state)
            S_IDLE: begin
                w_clear = 1'b1;
                if (i_start) w_state_nx = S_DECIDE;
                else         w_state_nx = S_IDLE;
            end
            S_DECIDE: begin
                if (i_confirm) begin
                    w_target_nx = f_clamp(i_ships_req);
                    w_state_nx  = S_PLACE;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_PLACE: begin
                if (i_confirm && (w_pl_cur == C_EMPTY)) begin
                    w_pl_we     = 1'b1;
                    w_pl_wd     = C_SHIP;
                    w_placed_nx = r_placed + SW'(1);
                    if (w_placed_nx == r_target) begin
                        w_pleft_nx = r_target;
                        w_state_nx = S_PC_PLACE;
                    end else begin
                        w_state_nx = r_state;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_PC_PLACE: begin
                w_pc_wi = w_cand_i;
                w_pc_wj = w_cand_j;
                if (r_cleft == r_target) begin
                    w_state_nx = S_PLAYER;
                end else if (w_cand_ok && (w_pc_cand == C_EMPTY)) begin
                    w_pc_we    = 1'b1;
                    w_pc_wd    = C_SHIP;
                    w_cleft_nx = r_cleft + SW'(1);
                    if (w_cleft_nx == r_target) w_state_nx = S_PLAYER;
                    else                        w_state_nx = r_state;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_PLAYER: begin
                if (i_fire && (w_pc_cur == C_EMPTY)) begin
                    w_pc_we    = 1'b1;
                    w_pc_wd    = C_MISS;
                    w_state_nx = S_PC_TURN;
                end else if (i_fire && (w_pc_cur == C_SHIP)) begin
                    w_pc_we    = 1'b1;
                    w_pc_wd    = C_HIT;
                    w_cleft_nx = r_cleft - SW'(1);
                    if (r_cleft == SW'(1)) w_state_nx = S_WIN;
                    else                   w_state_nx = S_PC_TURN;
                end else if (i_tick) begin
                    // A repeated shot is ignored, so the timer keeps counting through it
                    if (r_timer >= LP_TLAST) begin
                        w_timeout_nx = 1'b1;
                        w_state_nx   = S_PC_TURN;
                    end else begin
                        w_timer_nx = r_timer + TW'(1);
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_PC_TURN: begin
                w_pl_wi = w_cand_i;
                w_pl_wj = w_cand_j;
                if (w_pl_cand == C_EMPTY && w_cand_ok) begin
                    w_pl_we    = 1'b1;
                    w_pl_wd    = C_MISS;
                    w_state_nx = S_PLAYER;
                end else if (w_pl_cand == C_SHIP) begin
                    w_pl_we    = 1'b1;
                    w_pl_wd    = C_HIT;
                    w_pleft_nx = r_pleft - SW'(1);
                    if (r_pleft == SW'(1)) w_state_nx = S_LOSE;
                    else                   w_state_nx = S_PLAYER;
                end else begin
                    w_state_nx = r_state;
                end
            end
            S_WIN, S_LOSE: begin
                if (i_start) begin
                    w_clear    = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = r_state;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_timer_d = ((w_state_nx == S_PLAYER) && (r_state != S_PLAYER)) ? {TW{1'b0}} : w_timer_nx;

    // FSM state, cursor, counters and timeout pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ci      <= {CW{1'b0}};
            r_cj      <= {CW{1'b0}};
            r_target  <= {SW{1'b0}};
            r_placed  <= {SW{1'b0}};
            r_pleft   <= {SW{1'b0}};
            r_cleft   <= {SW{1'b0}};
            r_timer   <= {TW{1'b0}};
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_timeout <= w_timeout_nx;
            if (w_clear) begin
                r_ci     <= {CW{1'b0}};
                r_cj     <= {CW{1'b0}};
                r_target <= {SW{1'b0}};
                r_placed <= {SW{1'b0}};
                r_pleft  <= {SW{1'b0}};
                r_cleft  <= {SW{1'b0}};
                r_timer  <= {TW{1'b0}};
            end else begin
                r_ci     <= w_ci_nx;
                r_cj     <= w_cj_nx;
                r_target <= w_target_nx;
                r_placed <= w_placed_nx;
                r_pleft  <= w_pleft_nx;
                r_cleft  <= w_cleft_nx;
                r_timer  <= w_timer_d;
            end
        end
    end

    // Board storage: single-cell writes, bulk clear on reset or entering IDLE
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear) begin
            for (int a = 0; a < BOARD_N; a++) begin
                for (int b = 0; b < BOARD_N; b++) begin
                    r_pl[a][b] <= C_EMPTY;
                    r_pc[a][b] <= C_EMPTY;
                end
            end
        end else begin
            if (w_pl_we) r_pl[w_pl_wi][w_pl_wj] <= w_pl_wd;
            if (w_pc_we) r_pc[w_pc_wi][w_pc_wj] <= w_pc_wd;
        end
    end

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    always_ff @(posedge i_clk) begin
        if (i_rst) r_lfsr <= LP_SEED;
        else       r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign o_state        = r_state;
    assign o_cursor_i     = r_ci;
    assign o_cursor_j     = r_cj;
    assign o_ships_target = r_target;
    assign o_ships_placed = r_placed;
    assign o_player_left  = r_pleft;
    assign o_pc_left      = r_cleft;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_battleship_game_core.sv
// Directed bench for battleship_game_core: cursor table on clamp/wrap instances plus
// hand-written game sequences for placement, shots, turn timeout, win and lose.
module tb_battleship_game_core;

    localparam logic [7:0] P_NONE  = 8'h00;
    localparam logic [7:0] P_START = 8'h80;
    localparam logic [7:0] P_CONF  = 8'h40;
    localparam logic [7:0] P_FIRE  = 8'h20;
    localparam logic [7:0] P_TICK  = 8'h10;
    localparam logic [7:0] P_UP    = 8'h08;
    localparam logic [7:0] P_DOWN  = 8'h04;
    localparam logic [7:0] P_LEFT  = 8'h02;
    localparam logic [7:0] P_RIGHT = 8'h01;

    typedef struct {
        logic [7:0] mv;
        int         di;
        int         dj;
        int         wi;
        int         wj;
    } cur_vec_t;

    logic       clk = 1'b0;
    logic       rst, tick, start, confirm, fire, up, down, left, right;
    logic [2:0] ships_req, rd_i, rd_j;

    logic [1:0] pcell, ccell, w_pcell, w_ccell;
    logic [2:0] st, ci, cj, tgt, placed, pleft, cleft;
    logic [2:0] w_st, w_ci, w_cj, w_tgt, w_placed, w_pleft, w_cleft;
    logic       tout, w_tout;

    int n_chk = 0;
    int n_err = 0;

    battleship_game_core #(.BOARD_N(5), .MAX_SHIPS(5), .TURN_TICKS(3), .WRAP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start), .i_ships_req(ships_req),
        .i_confirm(confirm), .i_move_up(up), .i_move_down(down), .i_move_left(left),
        .i_move_right(right), .i_fire(fire), .i_rd_i(rd_i), .i_rd_j(rd_j),
        .o_rd_player_cell(pcell), .o_rd_pc_cell(ccell), .o_state(st),
        .o_cursor_i(ci), .o_cursor_j(cj), .o_ships_target(tgt), .o_ships_placed(placed),
        .o_player_left(pleft), .o_pc_left(cleft), .o_timeout(tout)
    );

    battleship_game_core #(.BOARD_N(5), .MAX_SHIPS(5), .TURN_TICKS(3), .WRAP(1)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start), .i_ships_req(ships_req),
        .i_confirm(confirm), .i_move_up(up), .i_move_down(down), .i_move_left(left),
        .i_move_right(right), .i_fire(fire), .i_rd_i(rd_i), .i_rd_j(rd_j),
        .o_rd_player_cell(w_pcell), .o_rd_pc_cell(w_ccell), .o_state(w_st),
        .o_cursor_i(w_ci), .o_cursor_j(w_cj), .o_ships_target(w_tgt), .o_ships_placed(w_placed),
        .o_player_left(w_pleft), .o_pc_left(w_cleft), .o_timeout(w_tout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] v);
        {start, confirm, fire, tick, up, down, left, right} = v;
        step();
        {start, confirm, fire, tick, up, down, left, right} = P_NONE;
    endtask

    task automatic wait_state(input logic [2:0] exp, input string nm);
        for (int k = 0; k < 300; k++) begin
            if (st == exp) break;
            step();
        end
        chk(nm, st, exp);
    endtask

    task automatic rd(input int i, input int j, output logic [1:0] p, output logic [1:0] c);
        rd_i = 3'(i);
        rd_j = 3'(j);
        #1;
        p = pcell;
        c = ccell;
    endtask

    task automatic count_cells(input logic [1:0] val, output int np, output int nc);
        logic [1:0] p, c;
        np = 0;
        nc = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                rd(i, j, p, c);
                if (p === val) np++;
                if (c === val) nc++;
            end
        end
    endtask

    task automatic find_pc(input logic [1:0] val, input bit from_end, output int fi, output int fj);
        logic [1:0] p, c;
        fi = 0;
        fj = 0;
        for (int k = 0; k < 25; k++) begin
            int idx;
            idx = from_end ? 24 - k : k;
            rd(idx / 5, idx % 5, p, c);
            if (c === val) begin
                fi = idx / 5;
                fj = idx % 5;
                break;
            end
        end
    endtask

    task automatic goto(input int ti, input int tj);
        for (int k = 0; k < 12; k++) begin
            if (int'(ci) == ti) break;
            pulse((int'(ci) > ti) ? P_UP : P_DOWN);
        end
        for (int k = 0; k < 12; k++) begin
            if (int'(cj) == tj) break;
            pulse((int'(cj) > tj) ? P_LEFT : P_RIGHT);
        end
        chk("goto_i", ci, ti);
        chk("goto_j", cj, tj);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cur_vec_t   tbl [16];
        logic [1:0] p, c;
        int         np, nc, s0i, s0j, s1i, s1j, ei, ej;
        bit         lost;

        tbl[0]  = '{P_UP,           0, 0, 4, 0};
        tbl[1]  = '{P_UP,           0, 0, 3, 0};
        tbl[2]  = '{P_UP,           0, 0, 2, 0};
        tbl[3]  = '{P_UP,           0, 0, 1, 0};
        tbl[4]  = '{P_LEFT,         0, 0, 1, 4};
        tbl[5]  = '{P_DOWN,         1, 0, 2, 4};
        tbl[6]  = '{P_RIGHT,        1, 1, 2, 0};
        tbl[7]  = '{P_UP | P_RIGHT, 0, 1, 1, 0};
        tbl[8]  = '{P_DOWN | P_LEFT, 1, 1, 2, 0};
        tbl[9]  = '{P_LEFT | P_RIGHT, 1, 0, 2, 4};
        tbl[10] = '{P_DOWN,         2, 0, 3, 4};
        tbl[11] = '{P_DOWN,         3, 0, 4, 4};
        tbl[12] = '{P_DOWN,         4, 0, 0, 4};
        tbl[13] = '{P_DOWN,         4, 0, 1, 4};
        tbl[14] = '{P_RIGHT,        4, 1, 1, 0};
        tbl[15] = '{P_NONE,         4, 1, 1, 0};

        {start, confirm, fire, tick, up, down, left, right} = P_NONE;
        ships_req = 3'd0;
        rd_i = 3'd0;
        rd_j = 3'd0;

        // Game A: reset state, count clamp, cursor table, duplicate placement
        rst = 1'b1;
        step();
        step();
        chk("rst_state", st, 0);
        chk("rst_cursor_i", ci, 0);
        chk("rst_cursor_j", cj, 0);
        chk("rst_target", tgt, 0);
        chk("rst_placed", placed, 0);
        chk("rst_pleft", pleft, 0);
        chk("rst_cleft", cleft, 0);
        chk("rst_timeout", tout, 0);
        rst = 1'b0;
        pulse(P_START);
        chk("start_decide", st, 1);
        ships_req = 3'd7;
        pulse(P_CONF);
        chk("clamp_high", tgt, 5);
        chk("decide_to_place", st, 2);
        for (int v = 0; v < 16; v++) begin
            pulse(tbl[v].mv);
            chk($sformatf("cur%0d_i", v), ci, tbl[v].di);
            chk($sformatf("cur%0d_j", v), cj, tbl[v].dj);
            chk($sformatf("wcur%0d_i", v), w_ci, tbl[v].wi);
            chk($sformatf("wcur%0d_j", v), w_cj, tbl[v].wj);
        end
        pulse(P_CONF);
        chk("place_one", placed, 1);
        rd(4, 1, p, c);
        chk("place_cell", p, 1);
        pulse(P_CONF);
        chk("dup_confirm", placed, 1);
        chk("dup_state", st, 2);
        rd(5, 1, p, c);
        chk("rd_out_of_range", p, 0);

        // Game B: two ships, PC placement, hit / miss / repeat / win
        rst = 1'b1;
        step();
        rst = 1'b0;
        ships_req = 3'd2;
        pulse(P_START);
        pulse(P_CONF);
        chk("target_two", tgt, 2);
        pulse(P_CONF);
        chk("b_placed1", placed, 1);
        pulse(P_RIGHT);
        pulse(P_CONF);
        chk("b_placed2", placed, 2);
        chk("b_pc_place", st, 3);
        chk("b_pleft", pleft, 2);
        wait_state(3'd4, "b_pc_place_done");
        chk("b_cleft", cleft, 2);
        count_cells(2'b01, np, nc);
        chk("b_pl_ships", np, 2);
        chk("b_pc_ships", nc, 2);
        find_pc(2'b01, 1'b0, s0i, s0j);
        find_pc(2'b01, 1'b1, s1i, s1j);
        find_pc(2'b00, 1'b0, ei, ej);
        goto(s0i, s0j);
        pulse(P_FIRE);
        chk("hit_state", st, 5);
        chk("hit_cleft", cleft, 1);
        rd(s0i, s0j, p, c);
        chk("hit_cell", c, 3);
        wait_state(3'd4, "b_back1");
        goto(ei, ej);
        pulse(P_FIRE);
        chk("miss_state", st, 5);
        rd(ei, ej, p, c);
        chk("miss_cell", c, 2);
        wait_state(3'd4, "b_back2");
        pulse(P_FIRE);
        chk("repeat_state", st, 4);
        chk("repeat_cleft", cleft, 1);
        rd(ei, ej, p, c);
        chk("repeat_cell", c, 2);
        goto(s1i, s1j);
        pulse(P_FIRE);
        chk("win_state", st, 6);
        chk("win_cleft", cleft, 0);
        pulse(P_START);
        chk("win_to_idle", st, 0);
        chk("idle_pleft", pleft, 0);
        rd(s0i, s0j, p, c);
        chk("idle_cleared", c, 0);

        // Game C: low clamp, then reset in the middle of a player turn
        ships_req = 3'd0;
        pulse(P_START);
        pulse(P_CONF);
        chk("clamp_low", tgt, 1);
        pulse(P_CONF);
        chk("c_pc_place", st, 3);
        chk("c_pleft", pleft, 1);
        wait_state(3'd4, "c_player_turn");
        pulse(P_DOWN);
        chk("c_moved", ci, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_state", st, 0);
        chk("mid_rst_ci", ci, 0);
        chk("mid_rst_cj", cj, 0);
        chk("mid_rst_target", tgt, 0);
        chk("mid_rst_placed", placed, 0);
        chk("mid_rst_pleft", pleft, 0);
        chk("mid_rst_cleft", cleft, 0);
        count_cells(2'b00, np, nc);
        chk("mid_rst_pl_empty", np, 25);
        chk("mid_rst_pc_empty", nc, 25);
        rst = 1'b0;
        step();

        // Game D: turn timeout, fire beating the last tick, PC sinks everything
        ships_req = 3'd5;
        pulse(P_START);
        pulse(P_CONF);
        for (int k = 0; k < 5; k++) begin
            pulse(P_CONF);
            if (k < 4) pulse(P_RIGHT);
        end
        chk("d_placed", placed, 5);
        chk("d_pleft", pleft, 5);
        wait_state(3'd4, "d_player_turn");
        chk("d_cleft", cleft, 5);
        pulse(P_TICK);
        pulse(P_TICK);
        chk("two_ticks_state", st, 4);
        chk("two_ticks_timeout", tout, 0);
        pulse(P_TICK);
        chk("timeout_pulse", tout, 1);
        chk("timeout_state", st, 5);
        step();
        chk("timeout_one_cycle", tout, 0);
        wait_state(3'd4, "d_back");
        find_pc(2'b00, 1'b0, ei, ej);
        goto(ei, ej);
        pulse(P_TICK);
        pulse(P_TICK);
        chk("timer_cleared", st, 4);
        pulse(P_TICK | P_FIRE);
        chk("fire_wins_state", st, 5);
        chk("fire_wins_timeout", tout, 0);
        rd(ei, ej, p, c);
        chk("fire_wins_cell", c, 2);
        lost = 1'b0;
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < 300; k++) begin
                if (st == 3'd4 || st == 3'd7) break;
                step();
            end
            if (st == 3'd7) begin
                lost = 1'b1;
                break;
            end
            pulse(P_TICK);
            pulse(P_TICK);
            pulse(P_TICK);
        end
        chk("lose_reached", lost, 1);
        chk("lose_state", st, 7);
        chk("lose_pleft", pleft, 0);
        pulse(P_START);
        chk("lose_to_idle", st, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/battleship_game_core.md
# battleship_game_core

Parametrised game engine for the Battleship design. It owns both N×N boards, the cursor, the ship-count decision, player and PC ship placement, shot resolution, turn timeout and win/lose detection in one synchronous block. It sits between the board-level controls (debounced button pulses, ship-count switches) and the VGA renderer, which reads cells through a combinational read port. It generalises the fixed 5×5 flow with a configurable board size, ship limit and cursor wrap mode, plus behaviour the earlier flow lacked: LFSR-driven PC play and a per-turn timeout.

## Interface
- BOARD_N, 5: board side, 2..8.
- MAX_SHIPS, 5: ship-count limit, 1..BOARD_N*BOARD_N.
- TURN_TICKS, 10: `tick` strobes allowed per player turn before forfeit, ≥1.
- WRAP, 0: 0 = cursor clamps at edges, 1 = cursor wraps.
- Derived: CW = $clog2(BOARD_N); SW = $clog2(MAX_SHIPS+1).
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- tick  in  1  1-cycle timebase strobe for the turn timer.
- start  in  1  IDLE→DECIDE; WIN/LOSE→IDLE.
- ships_req  in  SW  requested ship count.
- confirm  in  1  1-cycle pulse: latch count (DECIDE) or place ship (PLACE).
- move_up, move_down, move_left, move_right  in  1  1-cycle cursor pulses.
- fire  in  1  1-cycle pulse: shoot at cursor (PLAYER_TURN).
- rd_i, rd_j  in  CW  VGA read coordinate.
- rd_player_cell, rd_pc_cell  out  2  combinational cell at (rd_i,rd_j); 00 if out of range.
- state  out  3  IDLE=0, DECIDE=1, PLACE=2, PC_PLACE=3, PLAYER_TURN=4, PC_TURN=5, WIN=6, LOSE=7.
- cursor_i, cursor_j  out  CW  cursor row/column.
- ships_target, ships_placed, player_left, pc_left  out  SW  counters.
- timeout  out  1  1-cycle pulse when a player turn is forfeited.

## Operation
- Cell encoding: 00 empty, 01 ship, 10 miss, 11 hit. Ships are single cells.
- Cursor moves 1 cell per move pulse. Simultaneous pulses: only the highest priority applies (up > down > left > right). Up decrements i, left decrements j.
- Edge behaviour: WRAP=0 saturates at 0 and BOARD_N−1; WRAP=1 wraps BOARD_N−1↔0.
- The cursor moves in PLACE and PLAYER_TURN only.
- IDLE: boards cleared, counters 0. start→DECIDE.
- DECIDE: on confirm, ships_target ← clamp(ships_req, 1, MAX_SHIPS), then →PLACE.
- PLACE: on confirm:
  - Player cell at cursor is 00: it becomes 01, ships_placed++.
  - Cell already 01: ignored.
  - When ships_placed reaches ships_target: player_left ← ships_target, then →PC_PLACE.
- PC_PLACE, once per cycle:
  - Candidate (i,j) = (lfsr[CW-1:0], lfsr[2CW-1:CW]).
  - Valid (both < BOARD_N) and pc cell 00: cell becomes 01, pc_left++.
  - Otherwise retry next cycle.
  - When pc_left = ships_target: →PLAYER_TURN.
- PLAYER_TURN: on fire, pc cell at cursor:
  - 00: becomes 10, →PC_TURN.
  - 01: becomes 11, pc_left−−. →WIN if the result is 0, else →PC_TURN.
  - 10/11: ignored, stay; the timer keeps running.
- Turn timer: counts tick strobes, cleared on entering PLAYER_TURN. Reaching TURN_TICKS: timeout pulse, →PC_TURN, no shot taken. A fire in the same cycle wins over the timeout.
- PC_TURN: candidate as in PC_PLACE, against the player board.
  - Valid and cell 00: becomes 10, →PLAYER_TURN.
  - Valid and cell 01: becomes 11, player_left−−. →LOSE if the result is 0, else →PLAYER_TURN.
  - Invalid or cell already 10/11: retry next cycle.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'h01 on reset, advances every cycle in every state. It never reaches zero, and all N×N coordinates occur within 255 cycles.
- WIN/LOSE: hold the boards. start→IDLE, which clears everything.
- Inputs not listed for the current state are ignored.

## Timing
- Reset (rst high at an edge) forces, from the next cycle:
  - state=IDLE, all cells 00, cursor (0,0), all counters 0, timeout=0, lfsr=8'h01.
- rst mid-game aborts immediately; no partial update is retained.
- All outputs are registered except rd_player_cell and rd_pc_cell, which are combinational from the board registers.
- confirm, fire and moves take effect at the edge where they are sampled high. The updated cell, counter and state are visible the next cycle.
- A PC shot or placement completes in 1 cycle when the candidate is valid. Worst-case retry latency is < 255 cycles.
- The PLACE→PC_PLACE transition happens in the same edge as the final placement.

## Test plan
- Reset mid-PLAYER_TURN: next cycle state=0, cursor (0,0), all reads 00, counters 0.
- BOARD_N=5, WRAP=0: four move_up at (0,0) → stays (0,0). WRAP=1: one move_up → (4,0). up+right together → only i changes.
- DECIDE, ships_req=7, MAX_SHIPS=5 → ships_target=5. ships_req=0 → 1. Duplicate confirm on an occupied cell → ships_placed unchanged.
- Place 2 ships → PC_PLACE reaches pc_left=2 within 255 cycles, exactly 2 pc cells read 01, state=4.
- PLAYER_TURN: fire on a pc ship → cell 11, pc_left−1, state=5. Fire on a 10 cell → no change. Last ship hit → state=6.
- TURN_TICKS=3: three ticks without fire → timeout pulse, state=5. Fire coincident with the third tick → shot resolved, no timeout. PC sinking the last player ship → state=7, then start → state=0.
